pipe_stage_reg: RTL and testbench

Parametrised, elastic inter-stage pipeline register for the 5-stage core, generalising the fixed MEM/WB latch. It carries a control field, NUM_DATA data lanes and a destination-register index. It adds a valid/ready handshake, a 2-entry skid buffer (so in_ready_o is registered), flush-to-bubble and back-pressure. Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-stage parameter values.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_payload_reg.sv | 20 ++
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage register.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

   function automatic int payload_w(input int ctrl_w, input int num_data,
                                    input int data_w, input int rd_w);
      return ctrl_w + num_data * data_w + rd_w;
   endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload-wide register with load enable; clear wins over load.
module pipe_payload_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: main + skid entry, valid/ready, flush-to-bubble.
// Optional PIPE_STAGE_PERF_EN adds saturating stall and bubble counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W   = 2,
   parameter int DATA_W   = 32,
   parameter int NUM_DATA = 2,
   parameter int RD_W     = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [CTRL_W-1:0]          ctrl_i,
   input  logic [NUM_DATA*DATA_W-1:0] data_i,
   input  logic [RD_W-1:0]            rd_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [CTRL_W-1:0]          ctrl_o,
   output logic [NUM_DATA*DATA_W-1:0] data_o,
   output logic [RD_W-1:0]            rd_o
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]                stall_cnt_o,
   output logic [31:0]                bubble_cnt_o
`endif
);

   localparam int PW = payload_w(CTRL_W, NUM_DATA, DATA_W, RD_W);
   localparam int MW = PW - CTRL_W;

   state_t            state_q;
   state_t            state_d;
   logic              in_xfer;
   logic              out_xfer;
   logic              load_main;
   logic              load_skid;
   logic              main_from_skid;
   logic [MW-1:0]     main_d;
   logic [MW-1:0]     main_q;
   logic [PW-1:0]     skid_q;
   logic [CTRL_W-1:0] ctrl_next;

   assign in_xfer  = in_valid_i & in_ready_o;
   assign out_xfer = out_valid_o & out_ready_i;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               load_main = 1'b1;
               state_d   = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               load_main = 1'b1;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_d   = ST_TWO;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_xfer) begin
               load_main      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush drops the incoming entry; any output transfer this cycle has already happened.
      if (flush_i) begin
         state_d   = ST_EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
      end
   end

   assign main_d    = main_from_skid ? skid_q[MW-1:0] : {data_i, rd_i};
   assign ctrl_next = main_from_skid ? skid_q[PW-1 -: CTRL_W] : ctrl_i;

   // ctrl is kept apart from main so it can drop to zero while data and rd hold.
   pipe_payload_reg #(.W(MW)) u_main (
      .clk   (clk_i),
      .clear (rst_i),
      .load  (load_main),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_payload_reg #(.W(PW)) u_skid (
      .clk   (clk_i),
      .clear (rst_i | flush_i),
      .load  (load_skid),
      .d     ({ctrl_i, data_i, rd_i}),
      .q     (skid_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_EMPTY;
         out_valid_o <= 1'b0;
         in_ready_o  <= 1'b1;
         ctrl_o      <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_o <= (state_d != ST_EMPTY);
         in_ready_o  <= (state_d != ST_TWO);
         if (load_main) begin
            ctrl_o <= ctrl_next;
         end else if (state_d == ST_EMPTY) begin
            ctrl_o <= '0;
         end
      end
   end

   assign data_o = main_q[MW-1:RD_W];
   assign rd_o   = main_q[RD_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o  <= '0;
         bubble_cnt_o <= '0;
      end else begin
         if (out_valid_o && !out_ready_i && stall_cnt_o != SAT_MAX) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
         if (!out_valid_o && bubble_cnt_o != SAT_MAX) begin
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand sequences,
// then random traffic against a queue-based reference model.
module tb_pipe_stage_reg;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [1:0]  ctrl_i;
   logic [63:0] data_i;
   logic [4:0]  rd_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [1:0]  ctrl_o;
   logic [63:0] data_o;
   logic [4:0]  rd_o;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] bubble_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   pipe_stage_reg #(
      .CTRL_W   (2),
      .DATA_W   (32),
      .NUM_DATA (2),
      .RD_W     (5)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .ctrl_i      (ctrl_i),
      .data_i      (data_i),
      .rd_i        (rd_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .ctrl_o      (ctrl_o),
      .data_o      (data_o),
      .rd_o        (rd_o)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt_o  (stall_cnt_o),
      .bubble_cnt_o (bubble_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Reference model: a plain FIFO of at most two entries plus the last shown head.
   typedef struct packed {
      logic [1:0]  ctrl;
      logic [63:0] data;
      logic [4:0]  rd;
   } entry_t;

   entry_t      mq[$];
   logic [63:0] m_last_data = '0;
   logic [4:0]  m_last_rd   = '0;
   bit          m_in_ready  = 1'b1;
   logic [31:0] m_stall     = '0;
   logic [31:0] m_bubble    = '0;

   typedef struct {
      logic        rst, flush, in_valid, out_ready;
      logic [1:0]  ctrl;
      logic [63:0] data;
      logic [4:0]  rd;
      logic        ev, eir;
      logic [1:0]  ectrl;
      logic [63:0] edata;
      logic [4:0]  erd;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic ordy,
                               input logic [1:0] c, input logic [63:0] d, input logic [4:0] rd,
                               input logic ev, input logic eir, input logic [1:0] ec,
                               input logic [63:0] ed, input logic [4:0] erd);
      vec_t v;
      v.rst = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy;
      v.ctrl = c; v.data = d; v.rd = rd;
      v.ev = ev; v.eir = eir; v.ectrl = ec; v.edata = ed; v.erd = erd;
      return v;
   endfunction

   // Drives one cycle of inputs, advances the model, and steps past the clock edge.
   task automatic applyStimulus(input logic r, input logic f, input logic iv, input logic ordy,
                                input logic [1:0] c, input logic [63:0] d, input logic [4:0] rd);
      bit     in_x;
      bit     out_x;
      entry_t e;
      rst_i = r; flush_i = f; in_valid_i = iv; out_ready_i = ordy;
      ctrl_i = c; data_i = d; rd_i = rd;
      if (r) begin
         mq.delete();
         m_last_data = '0;
         m_last_rd   = '0;
         m_in_ready  = 1'b1;
         m_stall     = '0;
         m_bubble    = '0;
      end else begin
         if (mq.size() > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (mq.size() == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
         in_x  = iv && m_in_ready;
         out_x = (mq.size() > 0) && ordy;
         if (out_x) void'(mq.pop_front());
         e.ctrl = c; e.data = d; e.rd = rd;
         if (f) mq.delete();
         else if (in_x) mq.push_back(e);
         m_in_ready = (mq.size() < 2);
         if (mq.size() > 0) begin
            m_last_data = mq[0].data;
            m_last_rd   = mq[0].rd;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic ev, input logic eir,
                              input logic [1:0] ec, input logic [63:0] ed, input logic [4:0] erd);
      checkField({tag, " out_valid"}, 64'(out_valid_o), 64'(ev));
      checkField({tag, " in_ready"},  64'(in_ready_o),  64'(eir));
      checkField({tag, " ctrl"},      64'(ctrl_o),      64'(ec));
      checkField({tag, " data"},      data_o,           ed);
      checkField({tag, " rd"},        64'(rd_o),        64'(erd));
`ifdef PIPE_STAGE_PERF_EN
      checkField({tag, " stall_cnt"},  64'(stall_cnt_o),  64'(m_stall));
      checkField({tag, " bubble_cnt"}, 64'(bubble_cnt_o), 64'(m_bubble));
`endif
   endtask

   task automatic checkModel(input string tag);
      checkOutput(tag, mq.size() > 0, m_in_ready,
                  (mq.size() > 0) ? mq[0].ctrl : 2'b00, m_last_data, m_last_rd);
   endtask

   localparam logic [63:0] D3  = 64'h00000001_0000000A;
   localparam logic [63:0] D4  = 64'h00000002_0000000B;
   localparam logic [63:0] D5  = 64'h00000003_0000000C;
   localparam logic [63:0] D7  = 64'h00000011_00000022;
   localparam logic [63:0] D8  = 64'h00000033_00000044;
   localparam logic [63:0] D9  = 64'hDEADBEEF_00000099;
   localparam logic [63:0] D12 = 64'h00000055_00000066;
   localparam logic [63:0] D13 = 64'h00000077_00000088;
   localparam logic [63:0] D14 = 64'hCAFEF00D_12345678;
   localparam logic [63:0] D16 = 64'h00000099_000000AA;
   localparam logic [63:0] D18 = 64'h00000001_00000002;
   localparam logic [63:0] D19 = 64'h00000003_00000004;
   localparam logic [63:0] D21 = 64'h00000005_00000006;

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      ctrl_i = '0; data_i = '0; rd_i = '0;

      //           rst f  iv ordy ctrl data rd     ev eir ectrl edata erd
      vecs[0]  = mk(1, 0, 0, 1, 2'd0, '0,  5'd0,  0, 1, 2'd0, '0,  5'd0);
      vecs[1]  = mk(1, 0, 0, 1, 2'd0, '0,  5'd0,  0, 1, 2'd0, '0,  5'd0);
      vecs[2]  = mk(0, 0, 0, 1, 2'd0, '0,  5'd0,  0, 1, 2'd0, '0,  5'd0);
      vecs[3]  = mk(0, 0, 1, 1, 2'd3, D3,  5'd3,  1, 1, 2'd3, D3,  5'd3);
      vecs[4]  = mk(0, 0, 1, 1, 2'd1, D4,  5'd4,  1, 1, 2'd1, D4,  5'd4);
      vecs[5]  = mk(0, 0, 1, 1, 2'd2, D5,  5'd5,  1, 1, 2'd2, D5,  5'd5);
      vecs[6]  = mk(0, 0, 0, 1, 2'd0, '0,  5'd0,  0, 1, 2'd0, D5,  5'd5);
      vecs[7]  = mk(0, 0, 1, 0, 2'd1, D7,  5'd7,  1, 1, 2'd1, D7,  5'd7);
      vecs[8]  = mk(0, 0, 1, 0, 2'd2, D8,  5'd8,  1, 0, 2'd1, D7,  5'd7);
      vecs[9]  = mk(0, 0, 1, 0, 2'd3, D9,  5'd9,  1, 0, 2'd1, D7,  5'd7);
      vecs[10] = mk(0, 0, 0, 1, 2'd0, '0,  5'd0,  1, 1, 2'd2, D8,  5'd8);
      vecs[11] = mk(0, 0, 0, 1, 2'd0, '0,  5'd0,  0, 1, 2'd0, D8,  5'd8);
      vecs[12] = mk(0, 0, 1, 0, 2'd3, D12, 5'd9,  1, 1, 2'd3, D12, 5'd9);
      vecs[13] = mk(0, 0, 1, 0, 2'd1, D13, 5'd10, 1, 0, 2'd3, D12, 5'd9);
      vecs[14] = mk(0, 1, 1, 0, 2'd2, D14, 5'd11, 0, 1, 2'd0, D12, 5'd9);
      vecs[15] = mk(0, 0, 0, 1, 2'd0, '0,  5'd0,  0, 1, 2'd0, D12, 5'd9);
      vecs[16] = mk(0, 1, 1, 1, 2'd3, D16, 5'd12, 0, 1, 2'd0, D12, 5'd9);
      vecs[17] = mk(0, 0, 0, 1, 2'd0, '0,  5'd0,  0, 1, 2'd0, D12, 5'd9);
      vecs[18] = mk(0, 0, 1, 0, 2'd1, D18, 5'd13, 1, 1, 2'd1, D18, 5'd13);
      vecs[19] = mk(0, 0, 1, 0, 2'd2, D19, 5'd14, 1, 0, 2'd1, D18, 5'd13);
      vecs[20] = mk(1, 0, 0, 0, 2'd0, '0,  5'd0,  0, 1, 2'd0, '0,  5'd0);
      vecs[21] = mk(0, 0, 1, 1, 2'd3, D21, 5'd15, 1, 1, 2'd3, D21, 5'd15);
      vecs[22] = mk(0, 0, 0, 1, 2'd0, '0,  5'd0,  0, 1, 2'd0, D21, 5'd15);

      for (int i = 0; i < 23; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready,
                       vecs[i].ctrl, vecs[i].data, vecs[i].rd);
         checkOutput($sformatf("row%0d", i), vecs[i].ev, vecs[i].eir,
                     vecs[i].ectrl, vecs[i].edata, vecs[i].erd);
      end

      // Reset wins over a same-cycle flush while both entries are held.
      applyStimulus(0, 0, 1, 0, 2'd1, 64'h0000000A_0000000B, 5'd1);
      applyStimulus(0, 0, 1, 0, 2'd2, 64'h0000000C_0000000D, 5'd2);
      checkOutput("hs_fill", 1, 0, 2'd1, 64'h0000000A_0000000B, 5'd1);
      applyStimulus(1, 1, 1, 1, 2'd3, 64'h0000000E_0000000F, 5'd3);
      checkOutput("hs_rst_flush", 0, 1, 2'd0, 64'd0, 5'd0);

      // Flush alongside an output transfer: entry leaves, stage becomes a bubble.
      applyStimulus(0, 0, 1, 0, 2'd2, 64'h00000123_00000456, 5'd6);
      applyStimulus(0, 1, 1, 1, 2'd1, 64'h00000789_00000ABC, 5'd7);
      checkOutput("hs_flush_out", 0, 1, 2'd0, 64'h00000123_00000456, 5'd6);
      applyStimulus(0, 0, 0, 1, 2'd0, 64'd0, 5'd0);
      checkOutput("hs_after_flush", 0, 1, 2'd0, 64'h00000123_00000456, 5'd6);

      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 149) == 0,
                       $urandom_range(0, 39) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) != 0,
                       2'($urandom),
                       {$urandom, $urandom},
                       5'($urandom));
         checkModel($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
